// File: rtl/branch_feedback_generator.sv
// branch_feedback_generator
//   Tracks in-flight conditional-branch predictions between fetch and execute
//   and produces the predictor feedback stream. Fetch pushes {pc, prediction};
//   execute resolves branches in program order. Each matching resolve pops the
//   oldest entry and emits one registered feedback beat one cycle later.
//   Unmatched resolves raise a sticky sync error and clear the queue. A flush
//   discards all unresolved entries.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req_*             fetch push {valid, pc, prediction}; o_req_ready = not full
//   i_res_*             execute resolve {valid, pc, outcome}
//   i_flush             drop all unresolved entries and any same-cycle push
//   o_fb_*              registered feedback beat (valid/mispredict are pulses)
//   o_sync_err          sticky resolve/queue desynchronisation flag
//   o_occupancy         entries currently held
//   o_branch_cnt        feedback beats emitted, saturating
//   o_mispred_cnt       mispredicted beats, saturating

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package branch_feedback_generator_pkg;
  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;
endpackage

module branch_feedback_generator
  import branch_feedback_generator_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_req_valid,
  input  logic [`ADDR_WIDTH-1:0]     i_req_pc,
  input  BranchOutcome               i_req_prediction,
  output logic                       o_req_ready,
  input  logic                       i_res_valid,
  input  logic [`ADDR_WIDTH-1:0]     i_res_pc,
  input  BranchOutcome               i_res_outcome,
  input  logic                       i_flush,
  output logic                       o_fb_valid,
  output logic [`ADDR_WIDTH-1:0]     o_fb_pc,
  output BranchOutcome               o_fb_prediction,
  output BranchOutcome               o_fb_outcome,
  output logic                       o_mispredict,
  output logic                       o_sync_err,
  output logic [$clog2(DEPTH):0]     o_occupancy,
  output logic [CNT_WIDTH-1:0]       o_branch_cnt,
  output logic [CNT_WIDTH-1:0]       o_mispred_cnt
);

  localparam int                 PW       = $clog2(DEPTH);
  localparam logic [PW:0]        PTR_ONE  = (PW+1)'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [`ADDR_WIDTH-1:0]   pc_mem_q [DEPTH];
  BranchOutcome             pred_mem_q [DEPTH];

  logic                     fb_valid_q, fb_valid_d;
  logic [`ADDR_WIDTH-1:0]   fb_pc_q, fb_pc_d;
  BranchOutcome             fb_pred_q, fb_pred_d;
  BranchOutcome             fb_out_q, fb_out_d;
  logic                     mispredict_q, mispredict_d;
  logic                     sync_err_q, sync_err_d;
  logic [CNT_WIDTH-1:0]     branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]     mispred_cnt_q, mispred_cnt_d;

  logic                     empty_s, full_s, push_s, match_s, res_err_s, mis_s;
  logic [`ADDR_WIDTH-1:0]   head_pc_s;
  BranchOutcome             head_pred_s;

  // Queue status, resolve matching and all next-state values.
  always_comb begin
    empty_s      = (wr_ptr_q == rd_ptr_q);
    full_s       = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    head_pc_s    = pc_mem_q[rd_ptr_q[PW-1:0]];
    head_pred_s  = pred_mem_q[rd_ptr_q[PW-1:0]];
    push_s       = i_req_valid & ~full_s & ~i_flush;
    // Resolve only sees entries already stored: no same-cycle push bypass.
    match_s      = i_res_valid & ~empty_s & (head_pc_s == i_res_pc);
    res_err_s    = i_res_valid & ~match_s;
    mis_s        = match_s & (head_pred_s != i_res_outcome);

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fb_valid_d   = match_s;
    mispredict_d = mis_s;
    fb_pc_d      = fb_pc_q;
    fb_pred_d    = fb_pred_q;
    fb_out_d     = fb_out_q;
    sync_err_d   = sync_err_q | res_err_s;
    branch_cnt_d = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (i_flush || res_err_s) begin
      // Clearing wins over the push; the resolve (if matched) still reports.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (match_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end

    if (match_s) begin
      fb_pc_d   = head_pc_s;
      fb_pred_d = head_pred_s;
      fb_out_d  = i_res_outcome;
      if (branch_cnt_q != CNT_MAX) begin
        branch_cnt_d = branch_cnt_q + CNT_ONE;
      end else begin
        branch_cnt_d = branch_cnt_q;
      end
      if (mis_s && (mispred_cnt_q != CNT_MAX)) begin
        mispred_cnt_d = mispred_cnt_q + CNT_ONE;
      end else begin
        mispred_cnt_d = mispred_cnt_q;
      end
    end else begin
      fb_pc_d = fb_pc_q;
    end
  end

  // Pointer, feedback and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fb_valid_q    <= 1'b0;
      fb_pc_q       <= '0;
      fb_pred_q     <= NOT_TAKEN;
      fb_out_q      <= NOT_TAKEN;
      mispredict_q  <= 1'b0;
      sync_err_q    <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fb_valid_q    <= fb_valid_d;
      fb_pc_q       <= fb_pc_d;
      fb_pred_q     <= fb_pred_d;
      fb_out_q      <= fb_out_d;
      mispredict_q  <= mispredict_d;
      sync_err_q    <= sync_err_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Entry storage, written on accepted pushes only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        pred_mem_q[i] <= NOT_TAKEN;
      end
    end else if (push_s) begin
      pc_mem_q[wr_ptr_q[PW-1:0]]   <= i_req_pc;
      pred_mem_q[wr_ptr_q[PW-1:0]] <= i_req_prediction;
    end
  end

  assign o_req_ready     = ~full_s;
  assign o_occupancy     = wr_ptr_q - rd_ptr_q;
  assign o_fb_valid      = fb_valid_q;
  assign o_fb_pc         = fb_pc_q;
  assign o_fb_prediction = fb_pred_q;
  assign o_fb_outcome    = fb_out_q;
  assign o_mispredict    = mispredict_q;
  assign o_sync_err      = sync_err_q;
  assign o_branch_cnt    = branch_cnt_q;
  assign o_mispred_cnt   = mispred_cnt_q;

endmodule
